// File: rtl/popcnt_pkg.sv
// Shared types and constants for the popcount frame accumulator.
package popcnt_pkg;

    localparam int unsigned ACC_W_DEF  = 12;
    localparam int unsigned BEAT_W_DEF = 8;
    localparam int unsigned CNT_W      = 4;
    localparam int unsigned MAX_CNT    = 11;

    typedef enum logic {
        S_ACC = 1'b0,
        S_OUT = 1'b1
    } state_e;

    // An 11-input popcount can never legitimately exceed MAX_CNT.
    function automatic logic cnt_illegal(input logic [CNT_W-1:0] cnt);
        return cnt > CNT_W'(MAX_CNT);
    endfunction

endpackage

// File: rtl/popcnt_acc_add.sv
// Accumulator adder with overflow detect; POPCNT_ACC_SAT_EN selects clamp
// at all-ones instead of modulo wrap.
module popcnt_acc_add
    import popcnt_pkg::*;
#(
    parameter int unsigned ACC_W = ACC_W_DEF
) (
    input  logic [ACC_W-1:0] acc,
    input  logic [CNT_W-1:0] cnt,
    output logic [ACC_W-1:0] sum_c,
    output logic             ovf_c
);

    logic [ACC_W:0] wide;

    assign wide  = {1'b0, acc} + (ACC_W+1)'(cnt);
    assign ovf_c = wide[ACC_W];

`ifdef POPCNT_ACC_SAT_EN
    assign sum_c = ovf_c ? '1 : wide[ACC_W-1:0];
`else
    assign sum_c = wide[ACC_W-1:0];
`endif

endmodule

// File: rtl/popcnt_accumulator.sv
// Sums per-beat popcounts over a frame and presents one registered result
// per frame with valid/ready handshakes. Overflow mode: POPCNT_ACC_SAT_EN.
module popcnt_accumulator
    import popcnt_pkg::*;
#(
    parameter int unsigned ACC_W  = ACC_W_DEF,
    parameter int unsigned BEAT_W = BEAT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CNT_W-1:0]  in_cnt,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic [BEAT_W-1:0] out_beats,
    output logic              out_ovf,
    output logic              out_err
);

    localparam logic [BEAT_W-1:0] BEATS_MAX = '1;

    state_e             state_q;
    state_e             state_d;
    logic [ACC_W-1:0]   acc_q;
    logic [ACC_W-1:0]   sum_nxt;
    logic [BEAT_W-1:0]  beats_q;
    logic [BEAT_W-1:0]  beats_nxt;
    logic               ovf_q;
    logic               err_q;
    logic               add_ovf;
    logic               ovf_nxt;
    logic               err_nxt;
    logic               accept;
    logic               accept_last;

    assign out_valid   = (state_q == S_OUT);
    assign in_ready    = !(out_valid && !out_ready);
    assign accept      = in_valid && in_ready;
    assign accept_last = accept && in_last;

    popcnt_acc_add #(
        .ACC_W (ACC_W)
    ) u_add (
        .acc   (acc_q),
        .cnt   (in_cnt),
        .sum_c (sum_nxt),
        .ovf_c (add_ovf)
    );

    assign beats_nxt = (beats_q == BEATS_MAX) ? beats_q : beats_q + BEAT_W'(1);
    assign ovf_nxt   = ovf_q | add_ovf;
    assign err_nxt   = err_q | cnt_illegal(in_cnt);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_ACC;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state; a last beat taken while draining keeps S_OUT without a bubble
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_ACC: begin
                if (accept_last) begin
                    state_d = S_OUT;
                end
            end
            S_OUT: begin
                if (accept_last) begin
                    state_d = S_OUT;
                end else if (out_ready) begin
                    state_d = S_ACC;
                end
            end
            default: state_d = S_ACC;
        endcase
    end

    // Running frame accumulation and result capture
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q     <= '0;
            beats_q   <= '0;
            ovf_q     <= 1'b0;
            err_q     <= 1'b0;
            out_sum   <= '0;
            out_beats <= '0;
            out_ovf   <= 1'b0;
            out_err   <= 1'b0;
        end else if (accept) begin
            if (in_last) begin
                out_sum   <= sum_nxt;
                out_beats <= beats_nxt;
                out_ovf   <= ovf_nxt;
                out_err   <= err_nxt;
                acc_q     <= '0;
                beats_q   <= '0;
                ovf_q     <= 1'b0;
                err_q     <= 1'b0;
            end else begin
                acc_q     <= sum_nxt;
                beats_q   <= beats_nxt;
                ovf_q     <= ovf_nxt;
                err_q     <= err_nxt;
            end
        end
    end

endmodule

// File: tb/tb_popcnt_accumulator.sv
// Self-checking bench: directed frames plus random traffic against a
// frame-level reference model.
module tb_popcnt_accumulator;

    localparam int unsigned ACC_W  = 6;
    localparam int unsigned BEAT_W = 3;
    localparam int          SUM_MAX  = (1 << ACC_W) - 1;
    localparam int          BEAT_MAX = (1 << BEAT_W) - 1;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        in_cnt;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_sum;
    logic [BEAT_W-1:0] out_beats;
    logic              out_ovf;
    logic              out_err;

    int n_vec = 0;
    int n_bad = 0;

    // Model: true (unbounded) running frame totals and the expected result
    bit m_valid;
    int m_total;
    int m_n;
    bit m_err;
    int e_sum;
    int e_beats;
    bit e_ovf;
    bit e_err;

    popcnt_accumulator #(
        .ACC_W  (ACC_W),
        .BEAT_W (BEAT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_cnt    (in_cnt),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_beats (out_beats),
        .out_ovf   (out_ovf),
        .out_err   (out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int model_sum(input int total);
`ifdef POPCNT_ACC_SAT_EN
        return (total > SUM_MAX) ? SUM_MAX : total;
`else
        return total % (SUM_MAX + 1);
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_valid = 0; m_total = 0; m_n = 0; m_err = 0;
        e_sum = 0; e_beats = 0; e_ovf = 0; e_err = 0;
    endtask

    // One clock: check in_ready, advance model, then compare registered outputs
    task automatic tick();
        bit rdy;
        bit take;
        rdy = !(m_valid && !out_ready);
        #1;
        chk("in_ready", 32'(in_ready), 32'(rdy));
        take = in_valid && rdy && !rst;
        if (rst) begin
            model_reset();
        end else begin
            if (m_valid && out_ready) m_valid = 0;
            if (take) begin
                m_total += int'(in_cnt);
                m_n++;
                if (in_cnt > 4'd11) m_err = 1;
                if (in_last) begin
                    e_sum   = model_sum(m_total);
                    e_beats = (m_n > BEAT_MAX) ? BEAT_MAX : m_n;
                    e_ovf   = m_total > SUM_MAX;
                    e_err   = m_err;
                    m_valid = 1;
                    m_total = 0; m_n = 0; m_err = 0;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        if (m_valid) begin
            chk("out_sum",   32'(out_sum),   32'(e_sum));
            chk("out_beats", 32'(out_beats), 32'(e_beats));
            chk("out_ovf",   32'(out_ovf),   32'(e_ovf));
            chk("out_err",   32'(out_err),   32'(e_err));
        end
    endtask

    task automatic beat(input int cnt, input bit last);
        in_valid = 1'b1;
        in_cnt   = 4'(cnt);
        in_last  = last;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_last  = 1'b0;
        tick();
    endtask

    task automatic lit(input string name, input logic [31:0] act, input int exp);
        chk(name, act, 32'(exp));
    endtask

    initial begin
        model_reset();
        rst = 1'b1; in_valid = 1'b1; in_cnt = 4'd9; in_last = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        tick();
        tick();
        lit("rst_valid", 32'(out_valid), 0);
        lit("rst_sum",   32'(out_sum),   0);
        lit("rst_beats", 32'(out_beats), 0);
        lit("rst_ovf",   32'(out_ovf),   0);
        lit("rst_err",   32'(out_err),   0);
        rst = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        idle();

        // Four-beat frame, result one cycle after the last beat
        beat(11, 0); beat(11, 0); beat(11, 0); beat(5, 1);
        lit("f1_valid", 32'(out_valid), 1);
        lit("f1_sum",   32'(out_sum),   38);
        lit("f1_beats", 32'(out_beats), 4);
        lit("f1_ovf",   32'(out_ovf),   0);
        lit("f1_err",   32'(out_err),   0);
        idle();

        // Single-beat frame
        beat(7, 1);
        lit("f2_sum",   32'(out_sum),   7);
        lit("f2_beats", 32'(out_beats), 1);
        idle();

        // Backpressure then back-to-back last beat
        beat(2, 1);
        out_ready = 1'b0;
        in_valid = 1'b1; in_cnt = 4'd9; in_last = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            lit("stall_ready", 32'(in_ready), 0);
            lit("stall_sum",   32'(out_sum),  2);
        end
        out_ready = 1'b1;
        beat(3, 1);
        lit("b2b_valid", 32'(out_valid), 1);
        lit("b2b_sum",   32'(out_sum),   3);
        lit("b2b_beats", 32'(out_beats), 1);
        idle();

        // Overflow past 2^ACC_W-1
        for (int i = 0; i < 5; i++) beat(11, 0);
        beat(11, 1);
`ifdef POPCNT_ACC_SAT_EN
        lit("ovf_sum", 32'(out_sum), 63);
`else
        lit("ovf_sum", 32'(out_sum), 2);
`endif
        lit("ovf_flag", 32'(out_ovf), 1);
        idle();

        // Illegal count sets err only for its own frame
        beat(13, 0); beat(1, 1);
        lit("err_sum",  32'(out_sum), 14);
        lit("err_flag", 32'(out_err), 1);
        beat(5, 1);
        lit("err_next", 32'(out_err), 0);
        lit("err_nsum", 32'(out_sum), 5);
        idle();

        // Reset mid-frame discards partial beats
        beat(3, 0); beat(3, 0); beat(3, 0);
        rst = 1'b1; tick(); rst = 1'b0;
        beat(4, 1);
        lit("rmid_sum",   32'(out_sum),   4);
        lit("rmid_beats", 32'(out_beats), 1);
        idle();

        // Beat counter saturates
        for (int i = 0; i < 9; i++) beat(1, 0);
        beat(1, 1);
        lit("bsat_beats", 32'(out_beats), 7);
        lit("bsat_sum",   32'(out_sum),   10);
        idle();

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_cnt    = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(12, 15))
                                                    : 4'($urandom_range(0, 11));
            in_last   = ($urandom_range(0, 3) == 0);
            out_ready = ($urandom_range(0, 9) < 7);
            rst       = ($urandom_range(0, 199) == 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
